// File: rtl/tournament_predictor.sv
// Tournament branch predictor: a PC-indexed local table and a history-indexed
// global table (gshare or plain history), arbitrated by a per-PC chooser table.
// The global history shifts speculatively on every prediction and is restored
// from the branch's snapshot on mispredict. A sweep initialises all tables
// after reset before the first prediction is served.
module tournament_predictor #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LOCAL_LOG2 = 7,
    parameter int unsigned HIST_W     = 8,
    parameter int unsigned SEL_LOG2   = 7,
    parameter int unsigned CTR_W      = 2,
    parameter int unsigned GSHARE     = 1,
    parameter int unsigned MODE       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              busy_o,
    input  logic              rd_valid_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic              pre_taken,
    output logic              pre_src,
    output logic [HIST_W-1:0] pre_hist,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [HIST_W-1:0] hist_i,
    input  logic              res_taken,
    input  logic              mispred_i
);

    localparam int unsigned LDEP  = 1 << LOCAL_LOG2;
    localparam int unsigned GDEP  = 1 << HIST_W;
    localparam int unsigned SDEP  = 1 << SEL_LOG2;
    localparam int unsigned MAXLG = (LDEP > GDEP) ? LDEP : GDEP;
    localparam int unsigned MAXD  = (MAXLG > SDEP) ? MAXLG : SDEP;
    localparam int unsigned CNT_W = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [CTR_W-1:0] WNT  = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] WL   = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAXD - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [HIST_W-1:0] hist;

    logic [CTR_W-1:0] ltab [LDEP];
    logic [CTR_W-1:0] gtab [GDEP];
    logic [CTR_W-1:0] stab [SDEP];

    logic [LOCAL_LOG2-1:0] r_li, w_li;
    logic [HIST_W-1:0]     r_gi, w_gi;
    logic [SEL_LOG2-1:0]   r_si, w_si;
    logic                  lp, gp, cp;
    logic                  w_lc, w_gc;
    logic                  unused_addr_bits;

    function automatic logic [HIST_W-1:0] gidx(input logic [HIST_W-1:0] h,
                                               input logic [ADDR_W-1:0] a);
        return (GSHARE != 0) ? (h ^ a[HIST_W+1:2]) : h;
    endfunction

    function automatic logic [CTR_W-1:0] step(input logic [CTR_W-1:0] c, input logic up);
        if (up) return (c == CMAX) ? c : c + CTR_W'(1);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    assign r_li = raddr_i[LOCAL_LOG2+1:2];
    assign r_si = raddr_i[SEL_LOG2+1:2];
    assign r_gi = gidx(hist, raddr_i);
    assign w_li = waddr_i[LOCAL_LOG2+1:2];
    assign w_si = waddr_i[SEL_LOG2+1:2];
    assign w_gi = gidx(hist_i, waddr_i);

    assign lp   = ltab[r_li][CTR_W-1];
    assign gp   = gtab[r_gi][CTR_W-1];
    assign cp   = stab[r_si][CTR_W-1];
    assign w_lc = (ltab[w_li][CTR_W-1] == res_taken);
    assign w_gc = (gtab[w_gi][CTR_W-1] == res_taken);

    assign unused_addr_bits = ^{raddr_i, waddr_i};

    // Combinational prediction; forced to zero while the sweep is running
    always_comb begin
        pre_taken = 1'b0;
        pre_src   = 1'b0;
        pre_hist  = '0;
        if (state == RUN) begin
            pre_hist = hist;
            if (MODE == 0) begin
                pre_taken = lp;
                pre_src   = 1'b1;
            end else if (MODE == 1) begin
                pre_taken = gp;
                pre_src   = 1'b0;
            end else begin
                pre_taken = cp ? lp : gp;
                pre_src   = cp;
            end
        end
    end

    // Control FSM: init sweep counter, busy flag and speculative history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= INIT;
            cnt    <= '0;
            hist   <= '0;
            busy_o <= 1'b1;
        end else if (rdy) begin
            case (state)
                INIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state  <= RUN;
                        busy_o <= 1'b0;
                    end
                end
                RUN: begin
                    // a mispredict restore overrides this cycle's speculative shift
                    if (we_i && mispred_i)
                        hist <= {hist_i[HIST_W-2:0], res_taken};
                    else if (rd_valid_i)
                        hist <= {hist[HIST_W-2:0], pre_taken};
                end
                default: state <= INIT;
            endcase
        end
    end

    // Table writes: sweep defaults during INIT, resolved-branch training in RUN
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (state == INIT) begin
                if (32'(cnt) < LDEP) ltab[cnt[LOCAL_LOG2-1:0]] <= WNT;
                if (32'(cnt) < GDEP) gtab[cnt[HIST_W-1:0]]     <= WNT;
                if (32'(cnt) < SDEP) stab[cnt[SEL_LOG2-1:0]]   <= WL;
            end else if (we_i) begin
                ltab[w_li] <= step(ltab[w_li], res_taken);
                gtab[w_gi] <= step(gtab[w_gi], res_taken);
                if (MODE == 2 && w_lc != w_gc)
                    stab[w_si] <= step(stab[w_si], w_lc);
            end
        end
    end

endmodule

// File: tb/tb_tournament_predictor.sv
// Bench for tournament_predictor: a tournament instance and a local-only
// instance share stimulus; both are compared each cycle against a
// table-level reference model held in integer arrays.
module tb_tournament_predictor;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  h;
        bit          p;
    } br_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rd_valid_i = 1'b0;
    logic        we_i = 1'b0;
    logic        res_taken = 1'b0;
    logic        mispred_i = 1'b0;
    logic [31:0] raddr_i = '0;
    logic [31:0] waddr_i = '0;
    logic [7:0]  hist_i = '0;

    logic       busy_t, pt_t, ps_t, busy_l, pt_l, ps_l;
    logic [7:0] ph_t, ph_l;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: index 0 = local-only instance, 1 = tournament instance
    int lt [2][128];
    int gt [2][256];
    int ch [2][128];
    int hs [2];
    br_t q [$];

    always #5 clk = ~clk;

    tournament_predictor #(.ADDR_W(32), .LOCAL_LOG2(7), .HIST_W(8), .SEL_LOG2(7),
                           .CTR_W(2), .GSHARE(1), .MODE(2)) u_tour (
        .clk(clk), .rst(rst), .rdy(rdy), .busy_o(busy_t),
        .rd_valid_i(rd_valid_i), .raddr_i(raddr_i),
        .pre_taken(pt_t), .pre_src(ps_t), .pre_hist(ph_t),
        .we_i(we_i), .waddr_i(waddr_i), .hist_i(hist_i),
        .res_taken(res_taken), .mispred_i(mispred_i)
    );

    tournament_predictor #(.ADDR_W(32), .LOCAL_LOG2(7), .HIST_W(8), .SEL_LOG2(7),
                           .CTR_W(2), .GSHARE(1), .MODE(0)) u_loc (
        .clk(clk), .rst(rst), .rdy(rdy), .busy_o(busy_l),
        .rd_valid_i(rd_valid_i), .raddr_i(raddr_i),
        .pre_taken(pt_l), .pre_src(ps_l), .pre_hist(ph_l),
        .we_i(we_i), .waddr_i(waddr_i), .hist_i(hist_i),
        .res_taken(res_taken), .mispred_i(mispred_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic int lidx(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    function automatic int gidx(input int h, input logic [31:0] a);
        return (h ^ int'(a[9:2])) & 255;
    endfunction

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 3) ? 3 : v);
    endfunction

    function automatic bit m_src(input int m, input logic [31:0] a);
        if (m == 0) return 1'b1;
        return ch[m][lidx(a)] >= 2;
    endfunction

    function automatic bit m_taken(input int m, input logic [31:0] a);
        if (m_src(m, a)) return lt[m][lidx(a)] >= 2;
        return gt[m][gidx(hs[m], a)] >= 2;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            foreach (lt[m][i]) lt[m][i] = 1;
            foreach (gt[m][i]) gt[m][i] = 1;
            foreach (ch[m][i]) ch[m][i] = 2;
            hs[m] = 0;
        end
    endfunction

    // Apply one clock edge of the prediction/training rules to the model
    function automatic void model_edge();
        if (!rdy) return;
        for (int m = 0; m < 2; m++) begin
            int nh;
            int li;
            int gi;
            bit lc;
            bit gc;
            nh = hs[m];
            if (rd_valid_i) nh = ((hs[m] << 1) | int'(m_taken(m, raddr_i))) & 255;
            if (we_i) begin
                li = lidx(waddr_i);
                gi = gidx(int'(hist_i), waddr_i);
                lc = ((lt[m][li] >= 2) == res_taken);
                gc = ((gt[m][gi] >= 2) == res_taken);
                lt[m][li] = sat(lt[m][li] + (res_taken ? 1 : -1));
                gt[m][gi] = sat(gt[m][gi] + (res_taken ? 1 : -1));
                if (m == 1 && lc != gc) ch[m][li] = sat(ch[m][li] + (lc ? 1 : -1));
                if (mispred_i) nh = ((int'(hist_i) << 1) | int'(res_taken)) & 255;
            end
            hs[m] = nh;
        end
    endfunction

    task automatic check_pred(input string tag);
        check({tag, ".t_busy"},  busy_t, 0);
        check({tag, ".t_taken"}, pt_t, m_taken(1, raddr_i));
        check({tag, ".t_src"},   ps_t, m_src(1, raddr_i));
        check({tag, ".t_hist"},  ph_t, 32'(hs[1]));
        check({tag, ".l_taken"}, pt_l, m_taken(0, raddr_i));
        check({tag, ".l_src"},   ps_l, m_src(0, raddr_i));
        check({tag, ".l_hist"},  ph_l, 32'(hs[0]));
    endtask

    task automatic idle();
        rd_valid_i = 1'b0;
        we_i       = 1'b0;
        mispred_i  = 1'b0;
        res_taken  = 1'b0;
        hist_i     = '0;
    endtask

    // Called at a negedge with inputs driven: check, clock, advance model
    task automatic tick(input string tag);
        #1;
        check_pred(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic upd(input logic [31:0] a, input bit r);
        idle();
        we_i      = 1'b1;
        waddr_i   = a;
        res_taken = r;
        tick("upd");
    endtask

    // Release reset and count busy cycles; junk requests must be ignored
    task automatic sweep(input string tag);
        int n;
        n = 0;
        rdy = 1'b1;
        rd_valid_i = 1'b1; we_i = 1'b1; mispred_i = 1'b1; res_taken = 1'b1;
        hist_i = 8'hFF; raddr_i = 32'h2000; waddr_i = 32'h2000;
        rst = 1'b1;
        while (busy_t === 1'b1 && n < 1000) begin
            if (n == 100) begin
                check({tag, ".mid_taken"}, pt_t, 0);
                check({tag, ".mid_src"},   ps_t, 0);
                check({tag, ".mid_hist"},  ph_t, 0);
            end
            n++;
            @(negedge clk);
        end
        check({tag, ".len"}, n, 256);
        check({tag, ".l_busy"}, busy_l, 0);
        idle();
        model_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        check("reset.busy",  busy_t, 1);
        check("reset.taken", pt_t, 0);
        check("reset.src",   ps_t, 0);
        check("reset.hist",  ph_t, 0);
        check("reset.lbusy", busy_l, 1);
        @(negedge clk);
        sweep("sweep");

        // defaults after the sweep
        for (int i = 0; i < 8; i++) begin
            raddr_i = $urandom;
            #1;
            check("dflt.taken", pt_t, 0);
            check("dflt.src",   ps_t, 1);
            tick("dflt");
        end

        // local counter training and saturation
        upd(32'h1000, 1'b1);
        upd(32'h1000, 1'b1);
        raddr_i = 32'h1000; #1; check("m0.taken2", pt_l, 1); tick("m0");
        raddr_i = 32'h1004; #1; check("m0.other", pt_l, 0); tick("m0");
        for (int i = 0; i < 3; i++) upd(32'h1000, 1'b1);
        upd(32'h1000, 1'b0);
        raddr_i = 32'h1000; #1; check("m0.sat_nt1", pt_l, 1); tick("m0");
        upd(32'h1000, 1'b0);
        upd(32'h1000, 1'b0);
        raddr_i = 32'h1000; #1; check("m0.sat_nt3", pt_l, 0); tick("m0");

        // speculative shifts of not-taken predictions, then a restore
        for (int i = 0; i < 3; i++) begin
            idle(); rd_valid_i = 1'b1; raddr_i = 32'h3000;
            #1; check("spec.hist", ph_t, 0); check("spec.taken", pt_t, 0);
            tick("spec");
        end
        idle(); we_i = 1'b1; mispred_i = 1'b1; waddr_i = 32'h3004; hist_i = 8'h05; res_taken = 1'b1;
        tick("restore");
        idle(); #1; check("restore.t_hist", ph_t, 8'h0B); check("restore.l_hist", ph_l, 8'h0B);

        // restore beats a same-cycle speculative shift
        rd_valid_i = 1'b1; raddr_i = 32'h3000;
        we_i = 1'b1; mispred_i = 1'b1; waddr_i = 32'h3004; hist_i = 8'h80; res_taken = 1'b0;
        tick("collide");
        idle(); #1; check("collide.hist", ph_t, 8'h00);

        // alternating branch: chooser should migrate to the global component
        for (int it = 0; it < 64; it++) begin
            bit r;
            bit p;
            logic [7:0] h;
            r = (it % 2 == 0);
            idle(); rd_valid_i = 1'b1; raddr_i = 32'h2000;
            p = m_taken(1, 32'h2000);
            h = 8'(hs[1]);
            if (it >= 60) begin
                #1;
                check("alt.taken", pt_t, r);
                check("alt.src",   ps_t, 0);
            end
            tick("alt.pred");
            idle(); we_i = 1'b1; waddr_i = 32'h2000; hist_i = h; res_taken = r; mispred_i = (p != r);
            tick("alt.upd");
        end

        // reset mid-run during an update
        idle(); rd_valid_i = 1'b1; raddr_i = 32'h2000;
        we_i = 1'b1; waddr_i = 32'h2000; hist_i = 8'h33; res_taken = 1'b1; mispred_i = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("midrst.busy",   busy_t, 1);
        check("midrst.t_hist", ph_t, 0);
        check("midrst.l_hist", ph_l, 0);
        check("midrst.taken",  pt_t, 0);
        @(negedge clk);
        sweep("resweep");
        raddr_i = 32'h2000; #1; check("resweep.src", ps_t, 1); tick("resweep");
        for (int i = 0; i < 4; i++) begin
            raddr_i = 32'h2000 | (32'(i) << 2);
            tick("resweep");
        end

        // randomized traffic with in-flight branches and rdy stalls
        for (int c = 0; c < 1500; c++) begin
            br_t b;
            logic [31:0] a;
            rdy = ($urandom_range(0, 7) != 0);
            idle();
            a = 32'h4000 | (32'($urandom_range(0, 63)) << 2);
            raddr_i = a;
            rd_valid_i = 1'($urandom_range(0, 1));
            if (rdy && q.size() > 0 && $urandom_range(0, 1) == 1) begin
                b = q.pop_front();
                we_i = 1'b1; waddr_i = b.a; hist_i = b.h;
                res_taken = b.a[4] ^ ($urandom_range(0, 4) == 0);
                mispred_i = (res_taken != b.p);
            end else if (!rdy) begin
                we_i = 1'($urandom_range(0, 1)); waddr_i = a; hist_i = 8'($urandom);
                res_taken = 1'($urandom_range(0, 1)); mispred_i = 1'b1;
            end
            if (rdy && rd_valid_i) begin
                b.a = a;
                b.h = 8'(hs[1]);
                b.p = m_taken(1, a);
                q.push_back(b);
            end
            tick("rand");
        end
        rdy = 1'b1;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tournament_predictor.md
# tournament_predictor

Parametrised tournament branch predictor for the IF stage. It combines a PC-indexed local table and a history-indexed global table, selectable as gshare or plain history. A per-PC chooser table arbitrates between them, replacing the single global selector. The global history is speculative: it shifts on every prediction, the owner carries a snapshot with each branch, and the history is restored from that snapshot on mispredict. After reset, a sweep FSM initialises all tables before the first prediction.

## Interface
- ADDR_W, 32, instruction address width
- LOCAL_LOG2, 7, log2 local-table entries (index = addr[LOCAL_LOG2+1:2])
- HIST_W, 8, global history length; global table has 2^HIST_W entries
- SEL_LOG2, 7, log2 chooser entries (index = addr[SEL_LOG2+1:2])
- CTR_W, 2, saturating counter width (≥2) for all tables
- GSHARE, 1, 1: global index = hist ^ addr[HIST_W+1:2]; 0: global index = hist
- MODE, 2, 0 local only; 1 global only; 2 tournament
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when 0, no state changes (FSM, tables, history frozen)
- busy_o  out  1  init sweep in progress
- rd_valid_i  in  1  a branch is being predicted this cycle
- raddr_i  in  ADDR_W  PC of branch being predicted
- pre_taken  out  1  prediction (combinational)
- pre_src  out  1  1 = local component chose, 0 = global
- pre_hist  out  HIST_W  history before this prediction; owner stores it with the branch
- we_i  in  1  resolved-branch update strobe
- waddr_i  in  ADDR_W  PC of resolved branch
- hist_i  in  HIST_W  pre_hist snapshot of that branch
- res_taken  in  1  actual outcome
- mispred_i  in  1  resolved outcome differed from prediction (valid with we_i)

## Operation
- Constants: WNT = 2^(CTR_W-1)-1 (weakly not-taken); WL = 2^(CTR_W-1) (chooser weakly prefers local). Saturation at 0 and 2^CTR_W-1, never wraps.
- FSM states: INIT, RUN.
- Reset (rst=0, async): state←INIT, sweep counter←0, history←0.
- INIT: each rdy cycle writes WNT to local[i], global[i] and WL to chooser[i] for i = counter, where i is in range of each table. The counter increments each write. When counter = max(2^LOCAL_LOG2, 2^HIST_W, 2^SEL_LOG2)-1, the final entry is written and state→RUN next cycle.
- In INIT: busy_o=1, pre_taken=0, pre_src=0, pre_hist=0. we_i and rd_valid_i are ignored.
- Read (RUN): lp = local[li][MSB]; gp = global[gi(history, raddr_i)][MSB]; c = chooser[si][MSB].
  - pre_taken = MODE0 ? lp : MODE1 ? gp : (c ? lp : gp).
  - pre_src = MODE0 ? 1 : MODE1 ? 0 : c.
  - pre_hist = current history.
- Speculative history: on rd_valid_i in RUN, history ← {history[HIST_W-2:0], pre_taken} at clock edge.
- Update (we_i in RUN):
  - local[waddr li] steps toward res_taken.
  - global[gi(hist_i, waddr_i)] steps toward res_taken.
  - Chooser update (MODE2 only): compute lc = (local MSB == res_taken) and gc = (global MSB == res_taken), using pre-update values at the update indices. If lc≠gc, chooser[waddr si] steps +1 if lc, −1 if gc; otherwise it is unchanged.
  - If mispred_i: history ← {hist_i[HIST_W-2:0], res_taken}.
- Simultaneous rd_valid_i and we_i with mispred_i: restore wins; this cycle's speculative shift is discarded.
- Simultaneous rd_valid_i and we_i without mispred: speculative shift proceeds; table updates proceed.
- Read and update to the same entry in one cycle: read returns the pre-update value.

## Timing
- Prediction: zero latency, combinational from raddr_i and registered state.
- Table, history and chooser writes take effect at the next posedge with rdy=1. They are visible to reads in the following cycle.
- Reset sweep: max(table depths) rdy-cycles, then busy_o falls.
- rst asserted mid-sweep or mid-run: immediate return to INIT, history 0; the sweep restarts from 0.
- rdy=0: outputs still reflect current state; nothing advances.

## Test plan
- Reset sweep, defaults (LOCAL_LOG2=7, HIST_W=8, SEL_LOG2=7) -> busy_o high exactly 256 cycles. Then pre_taken=0 for any raddr_i, pre_src=1, pre_hist=0.
- MODE0, 2 taken updates at 0x1000 -> pre_taken=1 at 0x1000; 0x1004 still 0. Further updates saturate the counter at 3; 3 not-taken updates return pre_taken to 0.
- Speculative history, rd_valid_i on 3 consecutive cycles predicting 0,0,0 -> pre_hist 0x00 each cycle. Then mispred update with hist_i=0x05, res_taken=1 -> next-cycle pre_hist=0x0B.
- Same cycle: rd_valid_i, plus we_i with mispred_i, hist_i=0x80, res_taken=0 -> history=0x00, not shifted by the read.
- MODE2, alternating T/N branch at 0x2000, 64 iterations with mispredict restores -> chooser at 0x2000 reaches 0 (global). Final iterations predict correctly with pre_src=0.
- rst pulsed low mid-RUN during an update -> busy_o=1 immediately, history 0. All tables return to defaults after a full sweep.
